// File: rtl/fuzz_mix_datapath_if.sv
// fuzz_mix_datapath_if: five operand words into the mixing datapath, 350-bit result out
interface fuzz_mix_datapath_if;
  logic [5:0] wire4;
  logic [13:0] wire3;
  logic [2:0] wire2;
  logic [8:0] wire1;
  logic [16:0] wire0;
  logic [349:0] y;
  modport master(output wire4, wire3, wire2, wire1, wire0, input y);
  modport slave(input wire4, wire3, wire2, wire1, wire0, output y);
endinterface

// File: rtl/fuzz_mix_datapath.sv
// fuzz_mix_datapath: registered arithmetic/logic/stateful mixing of five input words into a 350-bit bus
module fuzz_mix_datapath #(
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input logic clk,
  input logic rst_n,
  fuzz_mix_datapath_if.slave bus
);
  logic [16:0] rot, mx, mn, w1z;
  logic [8:0] flags;
  logic [48:0] d1, d2;
  logic [17:0] sum;
  logic signed [20:0] prod, prod_w;
  logic [31:0] acc, lfsr;
  logic [15:0] cnt;
  logic [4:0] pop, pop_w;
  logic [67:0] hist;
  logic [33:0] rot_w;
  always_comb begin
    w1z = {8'b0, bus.wire1};
    rot_w = {bus.wire0, bus.wire0} << bus.wire2;
    prod_w = 21'($signed(bus.wire3)) * 21'($signed({1'b0, bus.wire4}));
    pop_w = '0;
    for (int i = 0; i < 17; i++) pop_w = pop_w + 5'(bus.wire0[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot <= '0;
      flags <= '0;
      mx <= '0;
      mn <= '0;
      d1 <= '0;
      d2 <= '0;
      sum <= '0;
      prod <= '0;
      acc <= '0;
      cnt <= '0;
      pop <= '0;
      hist <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      rot <= rot_w[33:17];
      flags <= {bus.wire3[13], bus.wire0 == '0, bus.wire0 > w1z, ^bus.wire0, ^bus.wire1,
                acc[31], &cnt, lfsr[0], bus.wire2 == '0};
      mx <= bus.wire0 > w1z ? bus.wire0 : w1z;
      mn <= bus.wire0 > w1z ? w1z : bus.wire0;
      d1 <= {bus.wire4, bus.wire3, bus.wire2, bus.wire1, bus.wire0};
      d2 <= d1;
      sum <= {1'b0, bus.wire0} + {9'b0, bus.wire1};
      prod <= prod_w;
      acc <= acc + {{18{bus.wire3[13]}}, bus.wire3};
      cnt <= cnt + 16'd1;
      pop <= pop_w;
      hist <= {hist[50:0], bus.wire0 ^ w1z};
      lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
  end
  assign bus.y = {rot, flags, mx, mn, d2, d1, sum, prod, acc, cnt, pop, hist, lfsr};
endmodule

// File: tb/tb_fuzz_mix_datapath.sv
// tb_fuzz_mix_datapath: directed and randomized checks of fuzz_mix_datapath against an arithmetic reference model
module tb_fuzz_mix_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  fuzz_mix_datapath_if bus();
  fuzz_mix_datapath #(.LFSR_SEED(32'h0000_0001)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [349:0] exp_y;
  logic [31:0] m_acc, m_lfsr;
  logic [15:0] m_cnt;
  logic [48:0] m_d1;
  logic [16:0] m_hist [4];

  task automatic model_reset();
    m_acc = 0;
    m_lfsr = 32'h1;
    m_cnt = 0;
    m_d1 = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    exp_y = 350'h1;
  endtask

  // expected y after one edge, built from the field definitions with integer arithmetic
  task automatic model_step(input logic [16:0] w0, input logic [8:0] w1, input logic [2:0] w2,
                            input logic [13:0] w3, input logic [5:0] w4);
    int a0, a1, a3, p, r, pc;
    logic [8:0] fl;
    logic [16:0] mxv, mnv;
    logic [17:0] s;
    logic [48:0] d2v;
    logic fb;
    a0 = int'(w0);
    a1 = int'(w1);
    a3 = w3[13] ? int'(w3) - 16384 : int'(w3);
    p = a3 * int'(w4);
    r = ((a0 << w2) | (a0 >> (17 - int'(w2)))) & 32'h1FFFF;
    pc = 0;
    for (int i = 0; i < 17; i++) pc += (a0 >> i) & 1;
    fl = {w3[13], a0 == 0, a0 > a1, ^w0, ^w1, m_acc[31], m_cnt == 16'hFFFF, m_lfsr[0], w2 == 3'd0};
    mxv = 17'(a0 > a1 ? a0 : a1);
    mnv = 17'(a0 > a1 ? a1 : a0);
    s = 18'(a0 + a1);
    d2v = m_d1;
    m_d1 = {w4, w3, w2, w1, w0};
    m_acc = m_acc + 32'(a3);
    m_cnt = m_cnt + 16'd1;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = 17'(a0 ^ a1);
    fb = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
    m_lfsr = {m_lfsr[30:0], fb};
    exp_y = {r[16:0], fl, mxv, mnv, d2v, m_d1, s, p[20:0], m_acc, m_cnt, 5'(pc),
             m_hist[3], m_hist[2], m_hist[1], m_hist[0], m_lfsr};
  endtask

  task automatic drive(input logic [16:0] w0, input logic [8:0] w1, input logic [2:0] w2,
                       input logic [13:0] w3, input logic [5:0] w4);
    bus.wire0 = w0;
    bus.wire1 = w1;
    bus.wire2 = w2;
    bus.wire3 = w3;
    bus.wire4 = w4;
    @(posedge clk);
    model_step(w0, w1, w2, w3, w4);
    #1;
  endtask

  task automatic drive_rand();
    drive(17'($urandom), 9'($urandom), 3'($urandom), 14'($urandom), 6'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.wire0 = 0; bus.wire1 = 0; bus.wire2 = 0; bus.wire3 = 0; bus.wire4 = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.y !== 350'h1) begin n_bad++; $display("FAIL reset_hold y=%0h exp=1", bus.y); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive_rand();
    n_cmp++;
    if (bus.y !== exp_y) begin n_bad++; $display("FAIL pre_async y=%0h exp=%0h", bus.y, exp_y); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.y !== 350'h1) begin n_bad++; $display("FAIL async_reset y=%0h exp=1", bus.y); end
  endtask

  task automatic test_first_edge();
    model_reset();
    bus.wire0 = 0; bus.wire1 = 0; bus.wire2 = 0; bus.wire3 = 0; bus.wire4 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.y[120:105] !== 16'd1) begin n_bad++; $display("FAIL first_cnt got=%0h exp=1", bus.y[120:105]); end
    n_cmp++;
    if (bus.y[31:0] !== 32'h3) begin n_bad++; $display("FAIL first_lfsr got=%0h exp=3", bus.y[31:0]); end
    n_cmp++;
    if (bus.y[332:324] !== 9'h083) begin n_bad++; $display("FAIL first_flags got=%0h exp=83", bus.y[332:324]); end
    n_cmp++;
    if (bus.y[349:333] !== 0 || bus.y[323:121] !== 0 || bus.y[104:32] !== 0) begin
      n_bad++; $display("FAIL first_zero_fields y=%0h", bus.y);
    end
  endtask

  task automatic test_rot();
    drive(17'h10000, 0, 3'd1, 0, 0);
    n_cmp++;
    if (bus.y[349:333] !== 17'h00001) begin n_bad++; $display("FAIL rot_wrap got=%0h exp=1", bus.y[349:333]); end
    drive(17'h00001, 0, 3'd3, 0, 0);
    n_cmp++;
    if (bus.y[349:333] !== 17'h00008) begin n_bad++; $display("FAIL rot_shift got=%0h exp=8", bus.y[349:333]); end
  endtask

  task automatic test_prod_acc();
    do_reset();
    drive(0, 0, 0, 14'h2000, 6'h3F);
    n_cmp++;
    if (bus.y[173:153] !== 21'h182000) begin n_bad++; $display("FAIL prod_neg got=%0h exp=182000", bus.y[173:153]); end
    do_reset();
    repeat (3) drive(0, 0, 0, 14'h3FFF, 0);
    n_cmp++;
    if (bus.y[152:121] !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL acc_neg got=%0h exp=fffffffd", bus.y[152:121]); end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.y[327] !== 1'b1) begin n_bad++; $display("FAIL acc_sign_flag got=%0b exp=1", bus.y[327]); end
  endtask

  task automatic test_max_min();
    drive(17'h1FFFF, 9'h1FF, 0, 0, 0);
    n_cmp++;
    if (bus.y[191:174] !== 18'h201FE) begin n_bad++; $display("FAIL sum_max got=%0h exp=201fe", bus.y[191:174]); end
    n_cmp++;
    if (bus.y[323:307] !== 17'h1FFFF || bus.y[306:290] !== 17'h001FF) begin
      n_bad++; $display("FAIL mx_mn got=%0h/%0h exp=1ffff/1ff", bus.y[323:307], bus.y[306:290]);
    end
    n_cmp++;
    if (bus.y[330] !== 1'b1 || bus.y[104:100] !== 5'd17) begin
      n_bad++; $display("FAIL gt_pop got=%0b/%0d exp=1/17", bus.y[330], bus.y[104:100]);
    end
    n_cmp++;
    if (bus.y[48:32] !== 17'h1FE00) begin n_bad++; $display("FAIL hist_new got=%0h exp=1fe00", bus.y[48:32]); end
  endtask

  task automatic test_back_to_back();
    logic [48:0] a, b;
    a = {6'h15, 14'h1234, 3'd5, 9'h0AB, 17'h0CDEF};
    b = {6'h2A, 14'h2ABC, 3'd2, 9'h154, 17'h13210};
    drive(a[16:0], a[25:17], a[28:26], a[42:29], a[48:43]);
    drive(b[16:0], b[25:17], b[28:26], b[42:29], b[48:43]);
    n_cmp++;
    if (bus.y[240:192] !== b || bus.y[289:241] !== a) begin
      n_bad++; $display("FAIL d1_d2 got=%0h/%0h exp=%0h/%0h", bus.y[240:192], bus.y[289:241], b, a);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    repeat (300) begin
      drive_rand();
      n_cmp++;
      if (bus.y !== exp_y) begin
        n_bad++;
        if (bad++ < 5) $display("FAIL random y=%0h exp=%0h", bus.y, exp_y);
      end
    end
  endtask

  task automatic test_cnt_wrap();
    int bad;
    bad = 0;
    do_reset();
    repeat (65536) begin
      drive_rand();
      n_cmp++;
      if (bus.y !== exp_y) begin
        n_bad++;
        if (bad++ < 5) $display("FAIL wrap_run y=%0h exp=%0h", bus.y, exp_y);
      end
    end
    n_cmp++;
    if (bus.y[120:105] !== 16'd0) begin n_bad++; $display("FAIL cnt_wrap got=%0h exp=0", bus.y[120:105]); end
    drive_rand();
    n_cmp++;
    if (bus.y[326] !== 1'b0 || bus.y[120:105] !== 16'd1) begin
      n_bad++; $display("FAIL cnt_after_wrap flag=%0b cnt=%0h exp=0/1", bus.y[326], bus.y[120:105]);
    end
  endtask

  task automatic test_cnt_flag();
    do_reset();
    repeat (65535) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (bus.y[326] !== 1'b1 || bus.y !== exp_y) begin
      n_bad++; $display("FAIL cnt_full_flag got=%0b exp=1", bus.y[326]);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_rot();
    test_prod_acc();
    test_max_min();
    test_back_to_back();
    test_random();
    test_cnt_wrap();
    test_cnt_flag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
